// File: rtl/au_addsub_pipe.sv
// -----------------------------------------------------------------------------
// au_addsub_pipe
//   Pipelined adder-subtractor with carry-in, carry-out and signed overflow.
//   The carry chain is cut into SEG-bit segments with one register stage per
//   segment, so the clock rate does not depend on WIDTH.
//   Latency is NSTG = ceil(WIDTH/SEG) cycles. Throughput is one beat per cycle.
//   The valid/ready handshake applies full backpressure.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   clr             synchronous flush of every in-flight beat
//   in_valid/ready  operand handshake (a, b, ci, add_sub)
//   add_sub         0: a+b+ci   1: a-b-ci (ci acts as borrow-in)
//   out_valid/ready result handshake (s, co, v)
//   co              carry-out of the MSB (subtraction: 1 = no borrow)
//   v               2's-complement overflow
//
// Optional feature
//   AU_ADDSUB_PIPE_SATURATE_EN : on overflow, s saturates to signed max/min,
//   following the sign of a. v and co are unaffected.
// -----------------------------------------------------------------------------
module au_addsub_pipe #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             add_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             v
);

    localparam int NSTG = (WIDTH + SEG - 1) / SEG;

    logic             w_adv;
    logic             w_acc;
    logic [WIDTH-1:0] w_bi;
    logic             w_cii;
    logic [NSTG-1:0]  r_vld_pipe;

    // The whole pipe moves as one unit. A held output therefore freezes every stage.
    assign w_adv     = ~out_valid | out_ready;
    assign in_ready  = w_adv & ~clr;
    assign w_acc     = in_valid & in_ready;
    assign out_valid = r_vld_pipe[NSTG-1];

    // Subtraction is computed as a + ~b + ~ci.
    assign w_bi  = b ^ {WIDTH{add_sub}};
    assign w_cii = ci ^ add_sub;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
        end else if (clr) begin
            r_vld_pipe <= '0;
        end else if (w_adv) begin
            for (int k = NSTG - 1; k > 0; k--) begin
                r_vld_pipe[k] <= r_vld_pipe[k-1];
            end
            r_vld_pipe[0] <= w_acc;
        end
    end

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        localparam int LO = k * SEG;                            // first bit of this segment
        localparam int SW = (k == NSTG - 1) ? WIDTH - LO : SEG; // segment width
        localparam int UW = WIDTH - LO;                         // operand bits still pending

        // w_a and w_b hold only the operand bits that are not yet summed. Bit 0 is this segment's LSB.
        logic [UW-1:0]    w_a;
        logic [UW-1:0]    w_b;
        logic             w_c;
        logic [SW:0]      w_sum;
        logic [LO+SW-1:0] w_sn;
        logic [LO+SW-1:0] w_res;
        logic [LO+SW-1:0] r_s;
        logic             r_c;

        if (k == 0) begin : g_src
            assign w_a  = a;
            assign w_b  = w_bi;
            assign w_c  = w_cii;
            assign w_sn = w_sum[SW-1:0];
        end else begin : g_src
            assign w_a  = g_stg[k-1].g_pass.r_a;
            assign w_b  = g_stg[k-1].g_pass.r_b;
            assign w_c  = g_stg[k-1].r_c;
            assign w_sn = {w_sum[SW-1:0], g_stg[k-1].r_s};
        end

        assign w_sum = {1'b0, w_a[SW-1:0]} + {1'b0, w_b[SW-1:0]} + {{SW{1'b0}}, w_c};

        if (k < NSTG - 1) begin : g_pass
            // Skew the upper operand bits forward to the stage that consumes them.
            logic [UW-SW-1:0] r_a;
            logic [UW-SW-1:0] r_b;

            assign w_res = w_sn;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv) begin
                    r_a <= w_a[UW-1:SW];
                    r_b <= w_b[UW-1:SW];
                end
            end
        end else begin : g_last
            logic w_ovf;
            logic r_v;

            // Carry into the MSB equals a^b^s at that bit. XOR it with the carry out.
            assign w_ovf = w_a[SW-1] ^ w_b[SW-1] ^ w_sum[SW-1] ^ w_sum[SW];

`ifdef AU_ADDSUB_PIPE_SATURATE_EN
            // w_a[SW-1] is a[WIDTH-1]. a is never inverted, so it selects the saturation direction.
            logic [WIDTH-1:0] w_sat;

            always_comb begin
                w_sat            = {WIDTH{~w_a[SW-1]}};
                w_sat[WIDTH-1]   = w_a[SW-1];
            end

            assign w_res = w_ovf ? w_sat : w_sn;
`else
            assign w_res = w_sn;
`endif

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_v <= 1'b0;
                end else if (w_adv) begin
                    r_v <= w_ovf;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s <= '0;
                r_c <= 1'b0;
            end else if (w_adv) begin
                r_s <= w_res;
                r_c <= w_sum[SW];
            end
        end
    end

    assign s  = g_stg[NSTG-1].r_s;
    assign co = g_stg[NSTG-1].r_c;
    assign v  = g_stg[NSTG-1].g_last.r_v;

endmodule
